// File: rtl/rom_word_fetch.sv
// Word-read bus slave that assembles a little-endian 32-bit word
// from four reads of an external combinational byte ROM.
module rom_word_fetch #(
  parameter int          ADDRESS_WIDTH = 8,
  parameter int          ROM_BYTES     = 136,
  parameter logic [7:0]  FILL_BYTE     = 8'h01,
  parameter int          WAIT_STATES   = 0,
  parameter logic [31:0] BASE_ADDR     = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     mem_valid,
  input  logic [31:0]              mem_addr,
  output logic                     mem_ready,
  output logic [31:0]              mem_rdata,
  output logic                     mem_err,
  output logic [ADDRESS_WIDTH-1:0] rom_addr,
  input  logic [7:0]               rom_data
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    ERR,
    DONE
  } state_t;

  localparam logic [32:0] WIN_LO =
    {1'b0, BASE_ADDR};
  localparam logic [32:0] WIN_HI =
    WIN_LO + (33'd1 << ADDRESS_WIDTH);
  localparam logic [3:0] WAIT_LAST =
    4'(WAIT_STATES);

  state_t                   state_q, state_d;
  logic [1:0]               k_q, k_d;
  logic [3:0]               wait_q, wait_d;
  logic [ADDRESS_WIDTH-1:0] offset_q, offset_d;
  logic [ADDRESS_WIDTH-1:0] raddr_q, raddr_d;
  logic [31:0]              rdata_q, rdata_d;

  logic                     in_win;
  logic                     aligned;
  logic [ADDRESS_WIDTH-1:0] fetch_addr;
  logic [ADDRESS_WIDTH:0]   byte_pos;
  logic                     fill;
  logic [7:0]               byte_val;

  always_comb begin
    in_win  = ({1'b0, mem_addr} >= WIN_LO)
           && ({1'b0, mem_addr} < WIN_HI);
    aligned = (mem_addr[1:0] == 2'b00);
    fetch_addr = offset_q
               + ADDRESS_WIDTH'(k_q);
    // untruncated position, so a wrap past
    // the window top still counts as unpopulated
    byte_pos = {1'b0, offset_q}
             + (ADDRESS_WIDTH + 1)'(k_q);
    fill     = 33'(byte_pos) >= 33'(ROM_BYTES);
    byte_val = fill ? FILL_BYTE : rom_data;
  end

  assign rom_addr  = (state_q == FETCH)
                   ? fetch_addr : raddr_q;
  assign mem_ready = (state_q == ERR)
                  || (state_q == DONE);
  assign mem_err   = (state_q == ERR);
  assign mem_rdata = rdata_q;

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    wait_d   = wait_q;
    offset_d = offset_q;
    raddr_d  = raddr_q;
    rdata_d  = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (mem_valid) begin
          rdata_d = 32'h0;
          if (aligned && in_win) begin
            state_d  = FETCH;
            offset_d = ADDRESS_WIDTH'(
                         mem_addr - BASE_ADDR);
            k_d      = 2'd0;
            wait_d   = 4'd0;
          end else begin
            state_d = ERR;
          end
        end
      end
      FETCH: begin
        raddr_d = fetch_addr;
        if (!mem_valid) begin
          state_d = IDLE;
          k_d     = 2'd0;
          wait_d  = 4'd0;
        end else if (wait_q == WAIT_LAST) begin
          rdata_d[{k_q, 3'b000} +: 8] = byte_val;
          wait_d = 4'd0;
          k_d    = k_q + 2'd1;
          if (k_q == 2'd3) begin
            state_d = DONE;
          end
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      ERR: begin
        state_d = IDLE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      k_q      <= 2'd0;
      wait_q   <= 4'd0;
      offset_q <= '0;
      raddr_q  <= '0;
      rdata_q  <= 32'h0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      wait_q   <= wait_d;
      offset_q <= offset_d;
      raddr_q  <= raddr_d;
      rdata_q  <= rdata_d;
    end
  end

endmodule
